// File: rtl/interval_arb_pkg.sv
// Shared types and the round-robin selection helper for interval_timer_arbiter.
package interval_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RUN  = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    localparam int MAX_REQ = 8;

    // First set bit of req scanning from last+1, wrapping modulo nreq.
    // Iterating from the far end lets the nearest candidate win the final overwrite.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input int last,
                                           input int nreq);
        logic [2:0] pick;
        int idx;
        pick = last[2:0];
        for (int k = MAX_REQ; k >= 1; k--) begin
            if (k <= nreq) begin
                idx = last + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (req[idx[2:0]]) begin
                    pick = idx[2:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/interval_arb_counter.sv
// Shared interval counter: synchronous clear, advance-gated increment, compare output.
// Optional prescaler compiled in with INTERVAL_ARB_PRESCALE_EN.
module interval_arb_counter
    import interval_arb_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         run,
    input  logic [N-1:0] cmp,
    output logic [N-1:0] q,
    output logic         match,
    output logic         tick
);

    logic [N-1:0] q_reg;

`ifdef INTERVAL_ARB_PRESCALE_EN
    logic [PW-1:0] presc_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_reg <= '0;
        end else if (clear) begin
            presc_reg <= '0;
        end else if (run) begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign tick = run && (presc_reg == {PW{1'b1}});
`else
    // Every RUN cycle is an advance point; PW only sizes the prescaler.
    if (PW >= 0) begin : g_every_cycle
        assign tick = run;
    end
`endif

    // Holding at the match value keeps the count at dur while the FSM sits in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg <= '0;
        end else if (clear) begin
            q_reg <= '0;
        end else if (tick && !match) begin
            q_reg <= q_reg + 1'b1;
        end
    end

    assign q     = q_reg;
    assign match = (q_reg == cmp);

endmodule

// File: rtl/interval_timer_arbiter.sv
// Round-robin arbiter sharing one interval counter among NREQ requesters.
// Define INTERVAL_ARB_PRESCALE_EN to advance the counter once per 2^PW cycles.
module interval_timer_arbiter
    import interval_arb_pkg::*;
#(
    parameter int N    = 8,
    parameter int NREQ = 4,
    parameter int PW   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] dur,
    input  logic              abort,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [NREQ-1:0]   done,
    output logic [N-1:0]      count
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t       state_reg, state_next;
    logic [IW-1:0]    last_reg;
    logic [IW-1:0]    winner;
    logic [N-1:0]     dur_q_reg;
    logic [N-1:0]     dur_sel;
    logic [NREQ-1:0]  owner_hot;
    logic [MAX_REQ-1:0] req_ext;
    logic             owner_req;
    logic             ctr_clear;
    logic             ctr_run;
    logic             ctr_tick;
    logic             ctr_match;

    assign req_ext = MAX_REQ'(req);
    assign winner  = IW'(rr_pick(req_ext, int'(last_reg), NREQ));

    // last_reg doubles as the current owner: it is loaded with the winner on the grant edge.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_owner
            assign owner_hot[gi] = (last_reg == IW'(gi));
        end
    endgenerate

    assign owner_req = |(req & owner_hot);

    always_comb begin
        dur_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IW'(i)) begin
                dur_sel = dur[i*N +: N];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (|req) begin
                    state_next = ARB_RUN;
                end
            end
            ARB_RUN: begin
                // Cancellation takes precedence over a coincident expiry.
                if (abort || !owner_req) begin
                    state_next = ARB_IDLE;
                end else if (ctr_tick && ctr_match) begin
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                state_next = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ARB_IDLE;
            last_reg  <= IW'(NREQ - 1);
            dur_q_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ARB_IDLE && |req) begin
                last_reg  <= winner;
                dur_q_reg <= dur_sel;
            end
        end
    end

    assign ctr_run   = (state_reg == ARB_RUN);
    assign ctr_clear = (state_reg == ARB_IDLE) || (state_next == ARB_IDLE);

    interval_arb_counter #(
        .N  (N),
        .PW (PW)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clear (ctr_clear),
        .run   (ctr_run),
        .cmp   (dur_q_reg),
        .q     (count),
        .match (ctr_match),
        .tick  (ctr_tick)
    );

    assign grant = (state_reg != ARB_IDLE) ? owner_hot : '0;
    assign busy  = (state_reg != ARB_IDLE);
    assign done  = (state_reg == ARB_DONE) ? owner_hot : '0;

endmodule

// File: tb/tb_interval_timer_arbiter.sv
// Self-checking bench for interval_timer_arbiter: vector table, corner sequences,
// and randomized traffic against an elapsed-time reference model.
module tb_interval_timer_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int PW   = 4;
`ifdef INTERVAL_ARB_PRESCALE_EN
    localparam int P = 1 << PW;
`else
    localparam int P = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] dur;
    logic              abort;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [NREQ-1:0]   done;
    logic [N-1:0]      count;

    int errors = 0;
    int checks = 0;

    interval_timer_arbiter #(.N(N), .NREQ(NREQ), .PW(PW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .dur   (dur),
        .abort (abort),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [3:0] req;
        logic [31:0] dur;
        logic       abort;
        logic [3:0] g;
        logic [3:0] d;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_outs(input string name, input logic [3:0] g, input logic [3:0] d,
                              input logic [7:0] c);
        check({name, ".grant"}, int'(grant), int'(g));
        check({name, ".busy"},  int'(busy),  int'(|g));
        check({name, ".done"},  int'(done),  int'(d));
        check({name, ".count"}, int'(count), int'(c));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        dur   = '0;
        abort = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: time elapsed since the grant edge decides every output.
    bit m_idle;
    int m_owner, m_last, m_k, m_dur;
    logic [3:0] e_g, e_d;
    logic [7:0] e_c;

    task automatic model_reset();
        m_idle = 1'b1;
        m_last = NREQ - 1;
        m_owner = 0;
        m_k = 0;
        m_dur = 0;
    endtask

    task automatic model_edge();
        int len;
        if (m_idle) begin
            if (req != '0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int idx;
                    idx = (m_last + k) % NREQ;
                    if (req[idx]) begin
                        m_owner = idx;
                        break;
                    end
                end
                m_last = m_owner;
                m_dur  = int'(dur[m_owner*N +: N]);
                m_k    = 0;
                m_idle = 1'b0;
            end
        end else begin
            len = (m_dur + 1) * P;
            if (m_k == len) m_idle = 1'b1;
            else if (abort || !req[m_owner]) m_idle = 1'b1;
            else m_k++;
        end
        if (m_idle) begin
            e_g = '0; e_d = '0; e_c = '0;
        end else begin
            len = (m_dur + 1) * P;
            e_g = 4'(1 << m_owner);
            e_d = (m_k == len) ? e_g : 4'd0;
            e_c = (m_k < len) ? 8'(m_k / P) : 8'(m_dur);
        end
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n, prev;
        bit wrapped;
        reset = 1'b1;
        req   = '0;
        dur   = '0;
        abort = 1'b0;
        #1;
        check_outs("reset_state", 4'd0, 4'd0, 8'd0);

        // Single request, dur[0]=5: grant for 7 cycles, count 0..5, done in the last.
        for (int i = 0; i <= 5; i++)
            vecs.push_back('{(i == 0), 4'b0001, 32'd5, 1'b0, 4'b0001, 4'b0000, 8'(i)});
        vecs.push_back('{1'b0, 4'b0001, 32'd5, 1'b0, 4'b0001, 4'b0001, 8'd5});
        vecs.push_back('{1'b0, 4'b0000, 32'd5, 1'b0, 4'b0000, 4'b0000, 8'd0});
        vecs.push_back('{1'b0, 4'b0000, 32'd5, 1'b0, 4'b0000, 4'b0000, 8'd0});
        // All requesting with zero durations: order 0,1,2,3,0 with an idle gap each.
        for (int i = 0; i < 5; i++) begin
            logic [3:0] oh;
            oh = 4'(1 << (i % 4));
            vecs.push_back('{(i == 0), 4'b1111, 32'd0, 1'b0, oh, 4'b0000, 8'd0});
            vecs.push_back('{1'b0, 4'b1111, 32'd0, 1'b0, oh, oh, 8'd0});
            vecs.push_back('{1'b0, 4'b1111, 32'd0, 1'b0, 4'b0000, 4'b0000, 8'd0});
        end

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            req   = vecs[i].req;
            dur   = vecs[i].dur;
            abort = vecs[i].abort;
            step();
            $display("vec %0d: req=%b grant=%b done=%b count=%0d", i, req, grant, done, count);
            check_outs($sformatf("vec%0d", i), vecs[i].g, vecs[i].d, vecs[i].c);
        end

        // Abort at count 3; requester 3 wins next among 1100.
        do_reset();
        req = 4'b0100;
        dur = 32'd10 << 16;
        step();
        check_outs("abort_grant", 4'b0100, 4'd0, 8'd0);
        repeat (3) step();
        check_outs("abort_cnt3", 4'b0100, 4'd0, 8'd3);
        abort = 1'b1;
        req = 4'b1100;
        step();
        check_outs("abort_idle", 4'd0, 4'd0, 8'd0);
        abort = 1'b0;
        step();
        check_outs("abort_next", 4'b1000, 4'd0, 8'd0);
        $display("seq abort: next grant=%b", grant);

        // Requester 1 withdraws; requester 0 granted after one idle cycle.
        do_reset();
        req = 4'b0010;
        dur = 32'd10 << 8;
        step();
        check_outs("wd_grant", 4'b0010, 4'd0, 8'd0);
        step();
        req = 4'b0001;
        step();
        check_outs("wd_idle", 4'd0, 4'd0, 8'd0);
        step();
        check_outs("wd_next", 4'b0001, 4'd0, 8'd0);
        $display("seq withdraw: next grant=%b", grant);

        // Asynchronous reset with count=7.
        do_reset();
        req = 4'b0001;
        dur = 32'd20;
        repeat (8) step();
        check_outs("rst_cnt7", 4'b0001, 4'd0, 8'd7);
        #2 reset = 1'b1;
        #1;
        check_outs("rst_async", 4'd0, 4'd0, 8'd0);
        req = 4'b1010;
        @(negedge clk);
        reset = 1'b0;
        step();
        check_outs("rst_after", 4'b0010, 4'd0, 8'd0);
        $display("seq reset: grant after release=%b", grant);

        // Full-scale duration runs to 255 without wrapping.
        do_reset();
        req = 4'b0001;
        dur = 32'd255;
        step();
        n = 0;
        prev = 0;
        wrapped = 1'b0;
        while (done == '0 && n < 300) begin
            step();
            n++;
            if (int'(count) < prev) wrapped = 1'b1;
            prev = int'(count);
        end
        check("max_dur_cycles", n, 256);
        check("max_dur_count", int'(count), 255);
        check("max_dur_nowrap", int'(wrapped), 0);
        $display("seq dur255: done after %0d cycles at count=%0d", n, count);
        req = '0;
        step();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if ($urandom_range(0, 9) < 3) req = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) dur[i*N +: N] = 8'($urandom_range(0, 6));
            abort = ($urandom_range(0, 24) == 0);
            model_edge();
            step();
            if (!m_idle && m_k == 0)
                $display("rand cyc %0d: grant owner=%0d dur=%0d", cyc, m_owner, m_dur);
            check_outs($sformatf("rand%0d", cyc), e_g, e_d, e_c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
